hazard_ctrl: RTL

- Pipeline hazard controller for the 5-stage LEGv8 core.
- Consumes the ID/EX register's outputs (memRead, writeReg), the IF/ID source-register fields, and the resolved branch from MEM.
- Drives the hold, bubble and flush controls back into PC, IF/ID, ID/EX and EX/MEM.
- Contains a small FSM so a load-use stall can span several cycles in no-forwarding builds.

---
 rtl/hazard_ctrl_pkg.sv | 24 ++
 rtl/hazard_ctrl_if.sv | 32 +++
 rtl/hazard_ctrl_load_use_cmp.sv | 23 ++
 rtl/hazard_ctrl.sv | 133 +++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
// Contents: state_e (RUN/STALL), XZR zero-register index, ctrl_t bundle of the five
// pipeline control outputs and its canonical values CTRL_IDLE/STALL/FLUSH/RESET.
package hazard_pkg;

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_e;

  localparam logic [4:0] XZR = 5'd31;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic exmem_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE  = 5'b11000;
  localparam ctrl_t CTRL_STALL = 5'b00010;
  // Redirect: PC and IF/ID still load (branch target / NOP), younger stages squashed.
  localparam ctrl_t CTRL_FLUSH = 5'b11111;
  localparam ctrl_t CTRL_RESET = 5'b00111;

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - hazard controller pipeline-side signal bundle
// Inputs to the controller: idex_memRead, idex_writeReg, ifid_registerRn, ifid_registerRm,
// ifid_usesRm, branch_taken. Outputs: pcWrite, ifidWrite, ifidFlush, idexBubble,
// exmemFlush, stall_active. master = pipeline side, slave = hazard controller.
interface hazard_ctrl_if #(parameter int REG_W = 5);

  logic             idex_memRead;
  logic [REG_W-1:0] idex_writeReg;
  logic [REG_W-1:0] ifid_registerRn;
  logic [REG_W-1:0] ifid_registerRm;
  logic             ifid_usesRm;
  logic             branch_taken;
  logic             pcWrite;
  logic             ifidWrite;
  logic             ifidFlush;
  logic             idexBubble;
  logic             exmemFlush;
  logic             stall_active;

  modport master (
    output idex_memRead, idex_writeReg, ifid_registerRn, ifid_registerRm,
           ifid_usesRm, branch_taken,
    input  pcWrite, ifidWrite, ifidFlush, idexBubble, exmemFlush, stall_active
  );

  modport slave (
    input  idex_memRead, idex_writeReg, ifid_registerRn, ifid_registerRm,
           ifid_usesRm, branch_taken,
    output pcWrite, ifidWrite, ifidFlush, idexBubble, exmemFlush, stall_active
  );

endinterface

// File: rtl/hazard_ctrl_load_use_cmp.sv
// rtl/hazard_ctrl_load_use_cmp.sv - combinational load-use hazard comparator
// Ports: idex_memRead, idex_writeReg, ifid_registerRn, ifid_registerRm, ifid_usesRm in;
// hit out. A load targeting the zero register never produces a hazard.
module load_use_cmp #(
  parameter int REG_W   = 5,
  parameter int XZR_IDX = 31
) (
  input  logic             idex_memRead,
  input  logic [REG_W-1:0] idex_writeReg,
  input  logic [REG_W-1:0] ifid_registerRn,
  input  logic [REG_W-1:0] ifid_registerRm,
  input  logic             ifid_usesRm,
  output logic             hit
);

  localparam logic [REG_W-1:0] XZR_L = REG_W'(XZR_IDX);

  assign hit = idex_memRead
             & (idex_writeReg != XZR_L)
             & ((idex_writeReg == ifid_registerRn)
                | (ifid_usesRm & (idex_writeReg == ifid_registerRm)));

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - LEGv8 5-stage pipeline hazard controller (load-use stall, branch flush)
// Ports: CLOCK, RESET (sync, active-high), hz (hazard_ctrl_if.slave).
// Optional build macro HAZARD_CTRL_PERF_EN adds perf_stalls[31:0] and perf_flushes[31:0].
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W        = 5,
  parameter int STALL_CYCLES = 1,
  parameter int XZR_IDX      = int'(XZR)
) (
  input  logic          CLOCK,
  input  logic          RESET,
  hazard_ctrl_if.slave  hz
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0]   perf_stalls,
  output logic [31:0]   perf_flushes
`endif
);

  localparam int CNT_W = $clog2(STALL_CYCLES + 1);

  logic             hit;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ctrl;
  logic             stall_evt;
  logic             flush_evt;

  load_use_cmp #(.REG_W(REG_W), .XZR_IDX(XZR_IDX)) u_cmp (
    .idex_memRead    (hz.idex_memRead),
    .idex_writeReg   (hz.idex_writeReg),
    .ifid_registerRn (hz.ifid_registerRn),
    .ifid_registerRm (hz.ifid_registerRm),
    .ifid_usesRm     (hz.ifid_usesRm),
    .hit             (hit)
  );

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ctrl      = CTRL_IDLE;
    stall_evt = 1'b0;
    flush_evt = 1'b0;
    if (RESET) begin
      ctrl    = CTRL_RESET;
      state_d = RUN;
      cnt_d   = '0;
    end else if (hz.branch_taken) begin
      // Any load in EX is wrong-path and gets bubbled, so a pending stall is dropped.
      ctrl      = CTRL_FLUSH;
      flush_evt = 1'b1;
      state_d   = RUN;
      cnt_d     = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (hit) begin
            ctrl      = CTRL_STALL;
            stall_evt = 1'b1;
            if (STALL_CYCLES > 1) begin
              state_d = STALL;
              cnt_d   = CNT_W'(STALL_CYCLES - 1);
            end
          end
        end
        STALL: begin
          // hit is ignored here; ID is re-checked once back in RUN.
          ctrl      = CTRL_STALL;
          stall_evt = 1'b1;
          cnt_d     = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign hz.pcWrite      = ctrl.pc_write;
  assign hz.ifidWrite    = ctrl.ifid_write;
  assign hz.ifidFlush    = ctrl.ifid_flush;
  assign hz.idexBubble   = ctrl.idex_bubble;
  assign hz.exmemFlush   = ctrl.exmem_flush;
  assign hz.stall_active = (state_q == STALL) & ~RESET;

`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] perf_stalls_q, perf_stalls_d;
  logic [31:0] perf_flushes_q, perf_flushes_d;

  always_comb begin
    perf_stalls_d  = perf_stalls_q;
    perf_flushes_d = perf_flushes_q;
    if (stall_evt && (perf_stalls_q != 32'hFFFF_FFFF)) begin
      perf_stalls_d = perf_stalls_q + 32'd1;
    end
    if (flush_evt && (perf_flushes_q != 32'hFFFF_FFFF)) begin
      perf_flushes_d = perf_flushes_q + 32'd1;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      perf_stalls_q  <= '0;
      perf_flushes_q <= '0;
    end else begin
      perf_stalls_q  <= perf_stalls_d;
      perf_flushes_q <= perf_flushes_d;
    end
  end

  assign perf_stalls  = perf_stalls_q;
  assign perf_flushes = perf_flushes_q;
`else
  logic unused_evt;
  assign unused_evt = stall_evt ^ flush_evt;
`endif

endmodule
